// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the multicycle MIPS memory side
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_DONE
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - DEPTH x 32 word store, one synchronous write port, one registered read port
//  clk    in  rising-edge clock
//  we     in  write enable
//  waddr  in  write word index
//  wdata  in  write data
//  raddr  in  read word index
//  rdata  out mem[raddr] registered on clk
module mem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Contents are deliberately not reset so a program image survives reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated memory responder for the multicycle MIPS controller
//  clk      in  rising-edge clock
//  reset_n  in  asynchronous active-low reset
//  req      in  request valid, held until ready
//  we       in  1 = store, 0 = load/fetch
//  addr     in  byte address
//  wdata    in  store data
//  ready    out one-cycle completion pulse
//  rdata    out load data, held after ready
//  err      out misaligned / out-of-range, valid only with ready
//  busy     out access accepted and not yet completed
module mem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ready,
  output logic [WORD_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              acc_err;
  logic              finish;
  logic              mem_we;
  logic [AW-1:0]     raddr;
  logic [WORD_W-1:0] mem_rdata;

  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[WORD_W-1:AW+2] != '0);

  // cnt holds the remaining wait states; at zero the access completes on this edge.
  assign finish = (state_q == MEM_WAIT) && (cnt_q == 4'd0);
  assign mem_we = finish && we_q && !acc_err;

  // In IDLE the read port looks at the incoming address so the registered
  // read data is already settled when the zero-wait case completes.
  assign raddr = (state_q == MEM_IDLE) ? addr[AW+1:2] : addr_q[AW+1:2];

  mem_array #(.DEPTH(DEPTH)) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = MEM_WAIT;
          busy_d  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = MEM_DONE;
          ready_d = 1'b1;
          err_d   = acc_err;
          if (!we_q) begin
            rdata_d = acc_err ? '0 : mem_rdata;
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      MEM_DONE: begin
        state_d = MEM_IDLE;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule
